image_collector: RTL and testbench
==================================

IMAGE_COLLECTOR -- requirements
Module: image_collector

Interface
REQ-001 SHALL have parameter N, default 4, meaning the image is N x N pixels (N >= 1).
REQ-002 SHALL have parameter W, default 16, meaning the pixel width: signed Q5.10 fixed point, so 16'h0400 = 1.0.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  meaning in_data carries a pixel.
REQ-006 SHALL have port in_data  input  W (signed)  meaning the pixel, in raster order, row-major.
REQ-007 SHALL have port in_sof  input  1  meaning this pixel is image index 0 (start of frame).
REQ-008 SHALL have port in_ready  output  1  meaning the collector accepts a pixel this cycle.
REQ-009 SHALL have port relu_en  input  1  meaning negative pixels are stored as 0.
REQ-010 SHALL have port image  output  unpacked [0:N*N-1] of W signed  meaning the collected image, fed directly to the 2x2 pooling stage.
REQ-011 SHALL have port out_valid  output  1  meaning image holds a complete frame.
REQ-012 SHALL have port out_ready  input  1  meaning the consumer has taken the frame.
REQ-013 SHALL have port frame_cnt  output  8  meaning the number of frames released, wrapping modulo 256.

Function
REQ-014 SHALL implement two states: FILL (in_ready=1, out_valid=0) and FULL (in_ready=0, out_valid=1).
REQ-015 SHALL accept a pixel only on a cycle with in_valid && in_ready ("accept").
REQ-016 SHALL, on accept, write the pixel to image[idx] and increment idx, where idx is an internal counter of width clog2(N*N)+1.
REQ-017 SHALL, with relu_en=1, write 0 for a pixel whose sign bit is 1, and write it unchanged otherwise; relu_en is sampled per accepted pixel.
REQ-018 SHALL, on an accept with in_sof=1, write the pixel to image[0] and set idx to 1, discarding any partial frame; the unwritten entries keep their old values.
REQ-019 SHALL, on the accept that writes index N*N-1, enter FULL on the next edge, so out_valid rises the cycle after the last accept (latency 1).
REQ-020 SHALL in FULL hold image, idx and all buffer entries stable; in_valid and in_sof are ignored.
REQ-021 SHALL in FULL, when out_ready=1, return to FILL on the next edge, clear idx to 0 and increment frame_cnt (255 wraps to 0); image retains its values until overwritten.
REQ-022 SHALL ignore out_ready while in FILL.
REQ-023 SHALL with N=1 enter FULL after every accepted pixel.
REQ-024 SHALL NOT accept a pixel and release a frame in the same cycle, because in_ready and out_valid are mutually exclusive.

Reset
REQ-025 SHALL, while rst_n=0, immediately (asynchronously) force state FILL, idx=0, every image entry to 0, out_valid=0, in_ready=1 and frame_cnt=0.
REQ-026 SHALL, on reset asserted mid-fill or in FULL, discard the partial or held frame; no out_valid pulse follows reset.
REQ-027 SHALL, after reset release, accept a pixel on the first clock edge with in_valid=1.

Verification
REQ-028 SHALL verify fill: N=4, relu_en=0, feed 16 pixels 0x0400, 0x0500, ... (+0x0100 each), one per cycle -> out_valid=1 the cycle after the 16th accept, image[0]=0x0400, image[15]=0x1300, in_ready=0.
REQ-029 SHALL verify ReLU: relu_en=1, pixels alternating 0xFC00 (-1.0) and 0x0400 -> even indices 0x0000, odd indices 0x0400; with relu_en=0 -> 0xFC00 is stored unchanged.
REQ-030 SHALL verify back-pressure: hold out_ready=0 for 10 cycles in FULL while driving in_valid=1 with 0x7FFF -> image unchanged, in_ready=0; then out_ready=1 -> FILL next cycle, frame_cnt 0->1.
REQ-031 SHALL verify resync: accept 5 pixels, then accept 0x0C00 with in_sof=1 plus 15 more pixels -> out_valid after exactly 16 accepts counted from the sof pixel, and image[0]=0x0C00.
REQ-032 SHALL verify reset mid-fill: pull rst_n low after 7 accepts, without waiting for a clock edge -> all image entries 0, out_valid=0, frame_cnt=0, in_ready=1; a full 16-pixel refill then completes normally.
REQ-033 SHALL verify wrap and gaps: release 256 frames with random in_valid gaps -> frame_cnt returns to 0, and no pixel is lost or duplicated in any frame.

Source files
------------

// File: rtl/image_collector.sv
// Image collector: gathers N x N raster-ordered pixels into a frame buffer,
// optionally clamping negative pixels to zero, and holds the complete frame
// for the downstream pooling stage until the consumer takes it.
module image_collector #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic signed [W-1:0] in_data,
    input  logic                in_sof,
    output logic                in_ready,
    input  logic                relu_en,
    output logic signed [W-1:0] image [0:N*N-1],
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          frame_cnt
);

    localparam int NPIX = N * N;
    localparam int IW   = $clog2(NPIX) + 1;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [IW-1:0]         idx_r;
    logic [IW-1:0]         idx_next_s;
    logic [IW-1:0]         wr_idx_s;
    logic signed [W-1:0]   pix_s;
    logic                  accept_s;
    logic                  release_s;
    logic                  last_s;
    logic [7:0]            frame_cnt_r;

    // Handshake decodes straight from the state register; FILL and FULL are exclusive
    assign in_ready  = (state_r == FILL);
    assign out_valid = (state_r == FULL);
    assign frame_cnt = frame_cnt_r;
    assign accept_s  = in_valid && (state_r == FILL);
    assign release_s = out_ready && (state_r == FULL);
    assign last_s    = (wr_idx_s == IW'(NPIX - 1));

    // Pixel conditioning (ReLU clamp) and write address (sof restarts at index 0)
    always_comb begin
        pix_s    = in_data;
        wr_idx_s = idx_r;
        if (relu_en && in_data[W-1]) begin
            pix_s = {W{1'b0}};
        end else begin
            pix_s = in_data;
        end
        if (in_sof) begin
            wr_idx_s = {IW{1'b0}};
        end else begin
            wr_idx_s = idx_r;
        end
    end

    // Next-state and index logic for the FILL/FULL controller
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        case (state_r)
            FILL: begin
                if (accept_s) begin
                    idx_next_s = wr_idx_s + IW'(1);
                    if (last_s) begin
                        state_next_s = FULL;
                    end else begin
                        state_next_s = FILL;
                    end
                end else begin
                    idx_next_s   = idx_r;
                    state_next_s = FILL;
                end
            end
            FULL: begin
                if (release_s) begin
                    state_next_s = FILL;
                    idx_next_s   = {IW{1'b0}};
                end else begin
                    state_next_s = FULL;
                    idx_next_s   = idx_r;
                end
            end
            default: begin
                state_next_s = FILL;
                idx_next_s   = {IW{1'b0}};
            end
        endcase
    end

    // Controller state, fill index and released-frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= FILL;
            idx_r       <= {IW{1'b0}};
            frame_cnt_r <= 8'd0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            if (release_s) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end
        end
    end

    // Frame buffer: only the addressed entry changes, and only on an accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPIX; i++) begin
                image[i] <= {W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NPIX; i++) begin
                if (accept_s && (wr_idx_s == IW'(i))) begin
                    image[i] <= pix_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_image_collector.sv
// Self-checking bench for image_collector (N=4, W=16): a frame-level model is
// compared against the DUT every cycle, plus hand-computed spot checks.
module tb_image_collector;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int NPIX = N * N;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic signed [W-1:0] in_data;
    logic                in_sof;
    logic                in_ready;
    logic                relu_en;
    logic signed [W-1:0] image [0:NPIX-1];
    logic                out_valid;
    logic                out_ready;
    logic [7:0]          frame_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    logic chk_on = 1'b0;

    // Model state: pixels stored so far in the current frame, frame held flag
    logic signed [W-1:0] m_img [0:NPIX-1];
    int                  m_cnt;
    logic                m_full;
    logic [7:0]          m_frames;

    image_collector #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_sof(in_sof), .in_ready(in_ready), .relu_en(relu_en), .image(image),
        .out_valid(out_valid), .out_ready(out_ready), .frame_cnt(frame_cnt)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Frame-level reference model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt    <= 0;
            m_full   <= 1'b0;
            m_frames <= 8'd0;
            for (int i = 0; i < NPIX; i++) m_img[i] <= 16'sd0;
        end else if (!m_full) begin
            if (in_valid) begin
                m_img[in_sof ? 0 : m_cnt] <= (relu_en && in_data < 0) ? 16'sd0 : in_data;
                m_cnt  <= (in_sof ? 0 : m_cnt) + 1;
                m_full <= ((in_sof ? 0 : m_cnt) + 1) == NPIX;
            end
        end else if (out_ready) begin
            m_full   <= 1'b0;
            m_cnt    <= 0;
            m_frames <= m_frames + 8'd1;
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (chk_on) begin
            int bad;
            bad = -1;
            for (int i = NPIX - 1; i >= 0; i--) if (image[i] !== m_img[i]) bad = i;
            n_chk++;
            if (in_ready === !m_full && out_valid === m_full &&
                frame_cnt === m_frames && bad < 0) begin
                n_pass++;
            end else begin
                $display("FAIL cycle_model t=%0t: in_ready=%b/%b out_valid=%b/%b frame_cnt=%0d/%0d img_idx=%0d got=%h req=%h",
                         $time, in_ready, !m_full, out_valid, m_full, frame_cnt, m_frames,
                         bad, (bad < 0) ? image[0] : image[bad], (bad < 0) ? m_img[0] : m_img[bad]);
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // One clock of stimulus; returns 1 time unit after the edge
    task automatic drive(input logic v, input logic [15:0] d, input logic sof,
                         input logic relu, input logic ordy);
        in_valid  = v;
        in_data   = d;
        in_sof    = sof;
        relu_en   = relu;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_release();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [15:0] v;
        int          base;
        logic        seq_ok;
        clk = 1'b0; rst_n = 1'b1;
        in_valid = 1'b0; in_data = 16'h0; in_sof = 1'b0; relu_en = 1'b0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_on = 1'b1;
        check("reset_in_ready", {15'd0, in_ready}, 16'd1);
        check("reset_out_valid", {15'd0, out_valid}, 16'd0);
        check("reset_frame_cnt", {8'd0, frame_cnt}, 16'd0);
        check("reset_image3", image[3], 16'h0000);
        #10 rst_n = 1'b1;

        // Plain fill, one pixel per cycle
        for (int i = 0; i < NPIX; i++) begin
            drive(1'b1, 16'h0400 + 16'(i) * 16'h0100, 1'b0, 1'b0, 1'b0);
            if (i == NPIX - 2) check("fill_not_early", {15'd0, out_valid}, 16'd0);
        end
        check("fill_out_valid", {15'd0, out_valid}, 16'd1);
        check("fill_in_ready", {15'd0, in_ready}, 16'd0);
        check("fill_img0", image[0], 16'h0400);
        check("fill_img15", image[15], 16'h1300);

        // Back-pressure: FULL holds while inputs toggle
        for (int i = 0; i < 10; i++) drive(1'b1, 16'h7FFF, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("hold_img5", image[5], 16'h0900);
        check("hold_in_ready", {15'd0, in_ready}, 16'd0);
        idle_release();
        check("release_out_valid", {15'd0, out_valid}, 16'd0);
        check("release_frame_cnt", {8'd0, frame_cnt}, 16'd1);

        // ReLU on, then off
        for (int i = 0; i < NPIX; i++) drive(1'b1, (i % 2 == 0) ? 16'hFC00 : 16'h0400, 1'b0, 1'b1, 1'b0);
        check("relu_even", image[14], 16'h0000);
        check("relu_odd", image[1], 16'h0400);
        idle_release();
        for (int i = 0; i < NPIX; i++) drive(1'b1, (i % 2 == 0) ? 16'hFC00 : 16'h0400, 1'b0, 1'b0, 1'b0);
        check("norelu_even", image[0], 16'hFC00);
        idle_release();

        // Resync: partial frame discarded by sof
        for (int i = 0; i < 5; i++) drive(1'b1, 16'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        drive(1'b1, 16'h0C00, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < NPIX; i++) begin
            drive(1'b1, 16'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            if (i == NPIX - 2) check("resync_not_early", {15'd0, out_valid}, 16'd0);
        end
        check("resync_out_valid", {15'd0, out_valid}, 16'd1);
        check("resync_img0", image[0], 16'h0C00);
        idle_release();
        check("resync_frame_cnt", {8'd0, frame_cnt}, 16'd4);

        // Asynchronous reset in the middle of a fill
        for (int i = 0; i < 7; i++) drive(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        seq_ok = 1'b1;
        for (int i = 0; i < NPIX; i++) if (image[i] !== 16'h0000) seq_ok = 1'b0;
        check("rst_image_zero", {15'd0, seq_ok}, 16'd1);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_frame_cnt", {8'd0, frame_cnt}, 16'd0);
        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        in_valid = 1'b0;
        #3 rst_n = 1'b1;
        for (int i = 0; i < NPIX; i++) drive(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0, 1'b0);
        check("refill_out_valid", {15'd0, out_valid}, 16'd1);
        check("refill_img15", image[15], 16'h200F);
        idle_release();
        check("refill_frame_cnt", {8'd0, frame_cnt}, 16'd1);

        // Wrap of the frame counter with random gaps
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int f = 0; f < 256; f++) begin
            base = f * NPIX;
            for (int p = 0; p < NPIX; p++) begin
                while ($urandom_range(0, 2) == 0)
                    drive(1'b0, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
                drive(1'b1, 16'(base + p), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            seq_ok = out_valid;
            for (int i = 0; i < NPIX; i++) if (image[i] !== 16'(base + i)) seq_ok = 1'b0;
            check("wrap_frame_seq", {15'd0, seq_ok}, 16'd1);
            for (int k = $urandom_range(0, 3); k > 0; k--)
                drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            idle_release();
        end
        check("wrap_frame_cnt", {8'd0, frame_cnt}, 16'd0);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
